// File: rtl/uart_tx_sched_pkg.sv
// rtl/uart_tx_sched_pkg.sv - shared types and constants for the UART transmit scheduler
//
// Contents:
//   ADDR_W / XLEN          MMIO address and data widths
//   IO map constants       base address and UART register offsets
//   UART_STAT_BUSY_BIT     bit of UART_STAT that reports transmitter busy
//   tx_state_e             scheduler FSM state encoding
//   tx_word()              zero-extends a byte to an MMIO data word

package uart_tx_sched_pkg;

    localparam int ADDR_W = 32;
    localparam int XLEN   = 32;

    localparam logic [ADDR_W-1:0] IO_BASE_ADDR        = 32'h8000_0000;
    localparam logic [ADDR_W-1:0] IO_UART_TX_OFFSET   = 32'h0000_0010;
    localparam logic [ADDR_W-1:0] IO_UART_STAT_OFFSET = 32'h0000_0014;

    localparam logic [ADDR_W-1:0] UART_TX_ADDR_DEF   = IO_BASE_ADDR + IO_UART_TX_OFFSET;
    localparam logic [ADDR_W-1:0] UART_STAT_ADDR_DEF = IO_BASE_ADDR + IO_UART_STAT_OFFSET;

    localparam int UART_STAT_BUSY_BIT = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_POLL  = 2'd1,
        S_GAP   = 2'd2,
        S_WRITE = 2'd3
    } tx_state_e;

    function automatic logic [XLEN-1:0] tx_word(input logic [7:0] b);
        return {{(XLEN-8){1'b0}}, b};
    endfunction

endpackage

// File: rtl/uart_tx_sched_byte_fifo.sv
// rtl/uart_tx_sched_byte_fifo.sv - synchronous FIFO buffering bytes awaiting transmission
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset (empties the FIFO)
//   push         write push_data at the tail (ignored when full)
//   push_data    data to write
//   pop          drop the head entry (ignored when empty)
//   head         current head entry, valid when !empty
//   full, empty  occupancy flags
//   count        number of entries held, 0..DEPTH

module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - buffered UART transmit front-end acting as an MMIO bus master
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_data/in_ready byte producer handshake (in_ready = !fifo_full)
//   mmio_req/we/addr/wdata   registered MMIO request, held while waiting for mmio_ready
//   mmio_rdata/mmio_ready    MMIO response; only rdata bit0 (busy) is used
//   fifo_count               bytes currently buffered
//   idle                     FIFO empty and scheduler idle

module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int                FIFO_DEPTH     = 16,
    parameter int                POLL_GAP       = 4,
    parameter logic [ADDR_W-1:0] UART_TX_ADDR   = UART_TX_ADDR_DEF,
    parameter logic [ADDR_W-1:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready,
    output logic                          mmio_req,
    output logic                          mmio_we,
    output logic [ADDR_W-1:0]             mmio_addr,
    output logic [XLEN-1:0]               mmio_wdata,
    input  logic [XLEN-1:0]               mmio_rdata,
    input  logic                          mmio_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          idle
);

    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int GAP_W = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);
    // POLL_GAP=0 still passes through S_GAP for exactly one cycle, which
    // gives the single req-low cycle between back-to-back polls.
    localparam logic [GAP_W-1:0] GAP_LOAD = (POLL_GAP == 0) ? '0 : GAP_W'(POLL_GAP - 1);

    tx_state_e         state_q, state_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              mmio_req_q, mmio_req_d;
    logic              mmio_we_q, mmio_we_d;
    logic [ADDR_W-1:0] mmio_addr_q, mmio_addr_d;
    logic [XLEN-1:0]   mmio_wdata_q, mmio_wdata_d;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]        fifo_head;
    logic [CW-1:0]     fifo_cnt;
    logic              uart_busy;
    logic              more_after_pop;
    logic              unused_rdata;

    byte_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (in_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    assign in_ready   = !fifo_full;
    assign fifo_push  = in_valid && !fifo_full;
    assign fifo_pop   = (state_q == S_WRITE) && mmio_ready;
    assign uart_busy  = mmio_rdata[UART_STAT_BUSY_BIT];
    assign fifo_count = fifo_cnt;
    assign idle       = (state_q == S_IDLE) && (fifo_cnt == '0);

    // Occupancy after this cycle's pop, counting a same-cycle push.
    assign more_after_pop = (fifo_cnt > CW'(1)) || fifo_push;

    assign unused_rdata = ^mmio_rdata[XLEN-1:1];

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_POLL;
                end
            end
            S_POLL: begin
                if (mmio_ready) begin
                    if (!uart_busy) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = GAP_LOAD;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = S_POLL;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            S_WRITE: begin
                if (mmio_ready) begin
                    state_d = more_after_pop ? S_POLL : S_IDLE;
                end
            end
        endcase
    end

    // Bus outputs are a function of the next state so they appear registered
    // in the same cycle the FSM enters the state. The FIFO head cannot change
    // while in S_WRITE, so wdata stays stable across wait cycles.
    always_comb begin
        mmio_req_d   = 1'b0;
        mmio_we_d    = 1'b0;
        mmio_addr_d  = '0;
        mmio_wdata_d = '0;
        case (state_d)
            S_POLL: begin
                mmio_req_d  = 1'b1;
                mmio_addr_d = UART_STAT_ADDR;
            end
            S_WRITE: begin
                mmio_req_d   = 1'b1;
                mmio_we_d    = 1'b1;
                mmio_addr_d  = UART_TX_ADDR;
                mmio_wdata_d = tx_word(fifo_head);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            gap_cnt_q    <= '0;
            mmio_req_q   <= 1'b0;
            mmio_we_q    <= 1'b0;
            mmio_addr_q  <= '0;
            mmio_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            mmio_req_q   <= mmio_req_d;
            mmio_we_q    <= mmio_we_d;
            mmio_addr_q  <= mmio_addr_d;
            mmio_wdata_q <= mmio_wdata_d;
        end
    end

    assign mmio_req   = mmio_req_q;
    assign mmio_we    = mmio_we_q;
    assign mmio_addr  = mmio_addr_q;
    assign mmio_wdata = mmio_wdata_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed self-checking bench for uart_tx_sched

module tb_uart_tx_sched;

    localparam logic [31:0] TX_ADDR   = 32'h8000_0010;
    localparam logic [31:0] STAT_ADDR = 32'h8000_0014;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mmio_req;
    logic        mmio_we;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic [31:0] mmio_rdata;
    logic        mmio_ready;
    logic [4:0]  fifo_count;
    logic        idle;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_sched dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mmio_req   (mmio_req),
        .mmio_we    (mmio_we),
        .mmio_addr  (mmio_addr),
        .mmio_wdata (mmio_wdata),
        .mmio_rdata (mmio_rdata),
        .mmio_ready (mmio_ready),
        .fifo_count (fifo_count),
        .idle       (idle)
    );

    // UART/MMIO slave model
    bit        stuck_busy = 1'b0;
    int        busy_after_write = 0;
    int        wait_cfg = 0;
    int        wait_left = 0;
    int        busy_cnt = 0;
    logic      model_busy;
    logic [7:0] wr_data [64];
    int        wr_n = 0;
    int        viol = 0;
    bit        in_gap = 1'b0;
    int        gap_run = 0;
    int        gap_len [128];
    int        gap_n = 0;

    assign model_busy = stuck_busy || (busy_cnt > 0);
    assign mmio_ready = mmio_req && (!mmio_we || wait_left == 0);
    assign mmio_rdata = {31'b0, model_busy};

    always @(posedge clk) begin
        if (!mmio_req || !mmio_we) begin
            wait_left <= wait_cfg;
        end else if (!mmio_ready) begin
            wait_left <= wait_left - 1;
        end
        if (mmio_req && mmio_we && mmio_ready) begin
            if (model_busy || mmio_addr !== TX_ADDR || mmio_wdata[31:8] !== 24'h0) viol <= viol + 1;
            if (wr_n < 64) wr_data[wr_n] <= mmio_wdata[7:0];
            wr_n <= wr_n + 1;
            busy_cnt <= busy_after_write;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (mmio_req && !mmio_we && mmio_ready && model_busy) begin
            in_gap  <= 1'b1;
            gap_run <= 0;
        end else if (in_gap) begin
            if (!mmio_req) begin
                gap_run <= gap_run + 1;
            end else begin
                if (gap_n < 128) gap_len[gap_n] <= gap_run;
                gap_n  <= gap_n + 1;
                in_gap <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_writes(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && wr_n < target; i++) @(negedge clk);
        check(tag, wr_n, target);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && idle !== 1'b1; i++) @(negedge clk);
        check(tag, {31'b0, idle}, 32'd1);
    endtask

    task automatic wait_we(input string tag, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (mmio_req === 1'b1 && mmio_we === 1'b1) break;
        end
        check(tag, {31'b0, mmio_req && mmio_we}, 32'd1);
    endtask

    initial begin
        int base;
        int gbase;
        int bad;
        int reqs;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);

        // reset state
        check("rst_req",   {31'b0, mmio_req}, 32'd0);
        check("rst_we",    {31'b0, mmio_we},  32'd0);
        check("rst_addr",  mmio_addr,  32'd0);
        check("rst_wdata", mmio_wdata, 32'd0);
        check("rst_ready", {31'b0, in_ready}, 32'd1);
        check("rst_count", {27'b0, fifo_count}, 32'd0);
        check("rst_idle",  {31'b0, idle}, 32'd1);
        rst = 1'b0;

        // single byte latency: push edge N, poll N+1, write N+2, idle N+3
        base = wr_n;
        push_byte(8'h55);
        @(negedge clk);
        check("t1_n_req",    {31'b0, mmio_req}, 32'd0);
        check("t1_n_count",  {27'b0, fifo_count}, 32'd1);
        @(negedge clk);
        check("t1_poll_req", {31'b0, mmio_req}, 32'd1);
        check("t1_poll_we",  {31'b0, mmio_we},  32'd0);
        check("t1_poll_addr", mmio_addr, STAT_ADDR);
        check("t1_poll_wdata", mmio_wdata, 32'd0);
        @(negedge clk);
        check("t1_wr_we",    {31'b0, mmio_req && mmio_we}, 32'd1);
        check("t1_wr_addr",  mmio_addr,  TX_ADDR);
        check("t1_wr_wdata", mmio_wdata, 32'h0000_0055);
        @(negedge clk);
        check("t1_idle",     {31'b0, idle}, 32'd1);
        check("t1_req_low",  {31'b0, mmio_req}, 32'd0);
        check("t1_logged",   {24'b0, wr_data[base]}, 32'h55);

        // burst of 3 with UART busy 20 cycles after each write
        busy_after_write = 20;
        base  = wr_n;
        gbase = gap_n;
        push_byte(8'h41);
        push_byte(8'h42);
        push_byte(8'h43);
        wait_writes("t2_nwrites", base + 3, 500);
        check("t2_b0", {24'b0, wr_data[base]},   32'h41);
        check("t2_b1", {24'b0, wr_data[base+1]}, 32'h42);
        check("t2_b2", {24'b0, wr_data[base+2]}, 32'h43);
        check("t2_no_busy_write", viol, 0);
        check("t2_gaps_seen", {31'b0, (gap_n - gbase) >= 2}, 32'd1);
        bad = 0;
        for (int i = gbase; i < gap_n; i++) if (gap_len[i] != 4) bad++;
        check("t2_gap_len", bad, 0);
        wait_idle("t2_idle", 200);
        busy_after_write = 0;
        repeat (25) @(negedge clk);

        // fill to 16 with STAT stuck busy
        stuck_busy = 1'b1;
        base = wr_n;
        for (int i = 0; i < 16; i++) push_byte(8'h60 + 8'(i));
        @(negedge clk);
        check("t3_full_count", {27'b0, fifo_count}, 32'd16);
        check("t3_full_ready", {31'b0, in_ready}, 32'd0);
        push_byte(8'hEE);
        @(negedge clk);
        check("t3_17th_count", {27'b0, fifo_count}, 32'd16);
        check("t3_no_write", wr_n, base);
        stuck_busy = 1'b0;
        wait_writes("t3_nwrites", base + 16, 2000);
        bad = 0;
        for (int i = 0; i < 16; i++) if (wr_data[base+i] != 8'h60 + 8'(i)) bad++;
        check("t3_order", bad, 0);
        wait_idle("t3_idle", 100);
        check("t3_count0", {27'b0, fifo_count}, 32'd0);
        check("t3_no_extra", wr_n, base + 16);

        // write held through 3 wait cycles
        wait_cfg = 3;
        base = wr_n;
        push_byte(8'h71);
        push_byte(8'h72);
        wait_we("t4_find_write", 50);
        for (int k = 0; k < 4; k++) begin
            check("t4_hold_addr",  mmio_addr, TX_ADDR);
            check("t4_hold_wdata", mmio_wdata, 32'h0000_0071);
            check("t4_hold_we",    {31'b0, mmio_req && mmio_we}, 32'd1);
            check("t4_hold_count", {27'b0, fifo_count}, 32'd2);
            check("t4_ready",      {31'b0, mmio_ready}, (k == 3) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        check("t4_count_dec", {27'b0, fifo_count}, 32'd1);
        wait_idle("t4_idle", 100);
        check("t4_order", {24'b0, wr_data[base+1]}, 32'h72);
        wait_cfg = 0;

        // push coinciding with write completion, 5 buffered
        stuck_busy = 1'b1;
        base = wr_n;
        for (int i = 0; i < 5; i++) push_byte(8'h81 + 8'(i));
        @(negedge clk);
        check("t5_count5", {27'b0, fifo_count}, 32'd5);
        stuck_busy = 1'b0;
        wait_we("t5_find_write", 50);
        check("t5_ready_now", {31'b0, mmio_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = 8'h86;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t5_count_same", {27'b0, fifo_count}, 32'd5);
        wait_writes("t5_nwrites", base + 6, 300);
        check("t5_last", {24'b0, wr_data[base+5]}, 32'h86);
        wait_idle("t5_idle", 100);

        // asynchronous reset during a stalled write
        stuck_busy = 1'b1;
        wait_cfg   = 5;
        base = wr_n;
        for (int i = 0; i < 4; i++) push_byte(8'h91 + 8'(i));
        stuck_busy = 1'b0;
        wait_we("t6_find_write", 50);
        check("t6_count4", {27'b0, fifo_count}, 32'd4);
        #2;
        rst = 1'b1;
        #1;
        check("t6_req_async",   {31'b0, mmio_req}, 32'd0);
        check("t6_count_async", {27'b0, fifo_count}, 32'd0);
        check("t6_idle_async",  {31'b0, idle}, 32'd1);
        check("t6_ready_async", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        wait_cfg = 0;
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mmio_req === 1'b1) reqs++;
        end
        check("t6_no_traffic", reqs, 0);
        check("t6_no_write", wr_n, base);
        check("t6_idle_after", {31'b0, idle}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Buffered transmit front-end that sequences the LED/UART MMIO peripheral's UART channel on behalf of a byte-stream producer (CPU store path, debug logger).
- Accepts bytes into a local FIFO and drains them as an MMIO bus master: polls UART_STAT and writes UART_TX only when the transmitter reports not-busy.
- Sits between the producer and the MMIO slave port; no byte written to UART_TX while busy is ever dropped.

Parameters:
- FIFO_DEPTH, 16, byte FIFO entries; power of two, minimum 2.
- POLL_GAP, 4, idle cycles inserted between consecutive STAT polls that return busy; 0 means back-to-back polling.
- UART_TX_ADDR, `IO_BASE_ADDR + `IO_UART_TX_OFFSET, MMIO address of the TX data register.
- UART_STAT_ADDR, `IO_BASE_ADDR + `IO_UART_STAT_OFFSET, MMIO address of the status register; bit0 = busy.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  producer has a byte.
- in_data  in  8  byte to transmit.
- in_ready  out  1  FIFO can accept; equals !fifo_full.
- mmio_req  out  1  MMIO request.
- mmio_we  out  1  1 = write, 0 = read.
- mmio_addr  out  `ADDR_W  request address.
- mmio_wdata  out  `XLEN  write data.
- mmio_rdata  in  `XLEN  read data; valid in the cycle mmio_ready=1.
- mmio_ready  in  1  request completes this cycle.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes currently buffered.
- idle  out  1  FIFO empty and FSM in S_IDLE.

Behaviour:
- Reset, asynchronous, any cycle, including mid-transaction: FIFO emptied (pointers and count 0); FSM to S_IDLE; gap counter 0. Outputs: mmio_req=0, mmio_we=0, mmio_addr=0, mmio_wdata=0, in_ready=1, fifo_count=0, idle=1. A frame already shifting in the UART completes on its own.
- Push: in_valid && in_ready at a rising edge writes in_data at the tail. With the FIFO full, in_ready=0 even if a pop occurs in the same cycle; no push-through.
- Pop: only on write completion (S_WRITE && mmio_ready). Same-cycle push and pop leaves fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH.
- The mmio_* outputs are registered, Moore-style from state. They are held stable while mmio_req=1 and mmio_ready=0.
- S_IDLE: mmio_req=0. If FIFO non-empty, go to S_POLL; mmio_req rises in the next cycle.
- S_POLL: req=1, we=0, addr=UART_STAT_ADDR, wdata=0. On mmio_ready:
  - rdata[0]=0: go to S_WRITE.
  - rdata[0]=1 and POLL_GAP>0: go to S_GAP and load the gap counter with POLL_GAP-1.
  - rdata[0]=1 and POLL_GAP=0: re-issue the poll with req deasserted for one cycle.
- S_GAP: req=0. Counter decrements each cycle; at 0, go to S_POLL.
- S_WRITE: req=1, we=1, addr=UART_TX_ADDR, wdata={24'b0, FIFO head}. On mmio_ready: pop, then:
  - return to S_POLL if the FIFO is still non-empty after the pop;
  - otherwise go to S_IDLE.
  - The UART asserts busy the cycle after the write, so the next poll reads busy=1.
- Latency, empty to first TX write with an idle UART and mmio_ready=req (peripheral is zero-wait):
  - push at edge N;
  - S_POLL request in cycle N+1;
  - S_WRITE request in cycle N+2;
  - byte accepted at the end of N+2.
- mmio_rdata bits other than bit0 are ignored.
- idle = (state==S_IDLE) && (fifo_count==0).

Decomposition:
- Shared package: FSM state enum (S_IDLE, S_POLL, S_GAP, S_WRITE, 2-bit), UART_STAT_BUSY_BIT=0, default address constants derived from the IO map.
- One sub-module: byte_fifo (parameterised width/depth synchronous FIFO, push/pop/full/empty/count).
- The FSM and MMIO drive stay in uart_tx_sched.

Test Plan:
- Single byte 0x55 into empty block, slave ready=req, STAT=0 -> poll cycle N+1, write addr=UART_TX_ADDR wdata=0x00000055 cycle N+2, idle=1 by N+3.
- Burst of 3 bytes 0x41,0x42,0x43, model STAT busy for 20 cycles after each TX write -> writes occur in order. None issued while model busy. Busy polls separated by exactly POLL_GAP=4 req-low cycles.
- Push 16 bytes with STAT stuck busy -> fifo_count=16, in_ready=0. 17th in_valid is not accepted. Release busy -> 16 writes, count returns to 0.
- Slave inserting 3 wait cycles (ready low) on a write -> addr/wdata/we held constant; pop only on the ready cycle; fifo_count decrements once.
- Push at the same edge as a write completes, FIFO holding 5 -> fifo_count stays 5.
- Assert rst during S_WRITE with 4 bytes buffered -> mmio_req=0 immediately (asynchronous), fifo_count=0, idle=1. After release, no MMIO traffic until a new push.
